ora_seq_check: RTL

- Downstream sink for the 1-in/1-out dependency-point stage: consumes the NoC-delivered packet stream that stage emits.
- Parses the packet header and checks per-source sequence-counter continuity and correct delivery (node/VC).
- Applies programmable back-pressure on ready and raises a sticky done after a target packet count.
- Used as a terminal checker in simulation-model NoC testbenches.

---
 rtl/ora_seq_check.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ora_seq_check.sv
// Terminal NoC sink: parses packet headers, checks per-source sequence
// continuity and delivery address, with programmable ready back-pressure.
module ora_seq_check #(
  parameter int N             = 16,
  parameter int NUM_VC        = 2,
  parameter int N_ADDR_WIDTH  = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int i0_WIDTH      = 32,
  parameter int i0_ID         = 0,
  parameter int i0_NODE       = 15,
  parameter int i0_VC         = 0,
  parameter int NUM_SRC       = 4,
  parameter int READY_PERIOD  = 0,
  parameter int DONE_COUNT    = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [i0_WIDTH-1:0]     i0_data_in,
  input  logic                    i0_valid_in,
  output logic                    i0_ready_out,
  output logic [31:0]             rx_count,
  output logic [15:0]             seq_err_count,
  output logic [15:0]             misroute_count,
  output logic                    err_pulse,
  output logic [N_ADDR_WIDTH-1:0] last_src,
  output logic                    done
);

  localparam int NA  = N_ADDR_WIDTH;
  localparam int VA  = VC_ADDR_WIDTH;
  localparam int W   = i0_WIDTH;
  localparam int DW  = W - 3*NA - 2*VA - 8;
  localparam int IW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RCW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  localparam logic [NA-1:0]  L_NODE = NA'(i0_NODE);
  localparam logic [VA-1:0]  L_VC   = VA'(i0_VC);
  localparam logic [RCW-1:0] RC_TOP = RCW'(READY_PERIOD - 1);
  localparam logic [31:0]    L_DONE = 32'(DONE_COUNT);

  logic [RCW-1:0] r_rc;

  logic          r_cap_valid;
  logic [NA-1:0] r_cap_src;
  logic [NA-1:0] r_cap_dst;
  logic [VA-1:0] r_cap_vc;
  logic [7:0]    r_cap_id;
  logic [DW-1:0] r_cap_data;

  logic          r_tbl_vld [NUM_SRC];
  logic [DW-1:0] r_tbl_exp [NUM_SRC];

  logic          w_acc;
  logic [IW-1:0] w_idx;
  logic          w_seq_err;
  logic          w_mis;
  logic [31:0]   w_rx_nxt;
  logic          w_unused;

  assign w_acc    = i0_valid_in & i0_ready_out;
  assign w_idx    = IW'(r_cap_id);
  assign w_unused = ^i0_data_in[W-1 -: NA+VA];

  assign w_seq_err = r_cap_valid & r_tbl_vld[w_idx] &
                     (r_cap_data != r_tbl_exp[w_idx]);
  assign w_mis     = r_cap_valid &
                     ((r_cap_dst != L_NODE) | (r_cap_vc != L_VC));
  assign w_rx_nxt  = (rx_count == '1) ? rx_count : rx_count + 32'd1;

  // Ready drops for the single cycle following the counter's last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rc         <= '0;
      i0_ready_out <= 1'b0;
    end else if (READY_PERIOD == 0) begin
      r_rc         <= '0;
      i0_ready_out <= 1'b1;
    end else begin
      r_rc         <= (r_rc == RC_TOP) ? '0 : r_rc + RCW'(1);
      i0_ready_out <= (r_rc != RC_TOP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_valid <= 1'b0;
      r_cap_src   <= '0;
      r_cap_dst   <= '0;
      r_cap_vc    <= '0;
      r_cap_id    <= '0;
      r_cap_data  <= '0;
    end else begin
      r_cap_valid <= w_acc;
      if (w_acc) begin
        r_cap_src  <= i0_data_in[W-NA-VA-1 -: NA];
        r_cap_dst  <= i0_data_in[W-2*NA-VA-1 -: NA];
        r_cap_vc   <= i0_data_in[W-3*NA-VA-1 -: VA];
        r_cap_id   <= i0_data_in[DW+7 -: 8];
        r_cap_data <= i0_data_in[DW-1:0];
      end
    end
  end

  // Table write lands at this edge, so a following compare sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_tbl_vld[i] <= 1'b0;
        r_tbl_exp[i] <= '0;
      end
      rx_count       <= '0;
      seq_err_count  <= '0;
      misroute_count <= '0;
      err_pulse      <= 1'b0;
      last_src       <= '0;
      done           <= 1'b0;
    end else begin
      err_pulse <= w_seq_err | w_mis;
      if (r_cap_valid) begin
        r_tbl_vld[w_idx] <= 1'b1;
        r_tbl_exp[w_idx] <= r_cap_data + DW'(1);
        rx_count         <= w_rx_nxt;
        last_src         <= r_cap_src;
        if (w_seq_err && seq_err_count != '1)
          seq_err_count <= seq_err_count + 16'd1;
        if (w_mis && misroute_count != '1)
          misroute_count <= misroute_count + 16'd1;
        if (w_rx_nxt >= L_DONE)
          done <= 1'b1;
      end
    end
  end

endmodule
